multiplier_pipe: RTL and testbench
==================================

# multiplier_pipe

- Parametrised, pipelined integer multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement, chosen per transaction; returns the exact 2·WIDTH-bit product.
- Balanced partial-product adder tree, one register stage per tree level, so it sustains one product per cycle at higher clock rates.
- Valid/ready handshake on both sides plus a sideband tag; sits between datapath producers (e.g. MAC/filter front-ends) and their accumulators.

## Interface
- WIDTH, 8 — operand width; power of two, 4..32.
- TAG_W, 4 — sideband tag width, ≥1; carried unmodified alongside the operation.
- clk  in  1  — single clock, rising edge.
- rst  in  1  — synchronous, active-high reset.
- in_valid  in  1  — operand beat valid.
- in_ready  out  1  — block accepts a beat this cycle.
- in_a  in  WIDTH  — multiplicand.
- in_b  in  WIDTH  — multiplier.
- in_signed  in  1  — 1: both operands two's-complement; 0: both unsigned.
- in_tag  in  TAG_W  — sideband, returned with the result.
- out_valid  out  1  — result valid.
- out_ready  in  1  — consumer accepts the result.
- out_product  out  2·WIDTH  — exact product.
- out_tag  out  TAG_W  — tag of that product.

## Operation
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Partial products:
  - Row i = in_b[i] ? in_a << i : 0.
  - Each row is extended to 2·WIDTH bits: sign-extended if in_signed, zero-extended otherwise.
  - If in_signed, the row for in_b[WIDTH-1] is negated (two's-complement subtraction) rather than added.
- Adder tree:
  - Rows are summed pairwise in a balanced tree of LEVELS = log2(WIDTH) levels.
  - All adds are 2·WIDTH bits wide, modulo 2^(2·WIDTH); the final result is always exact.
- Pipeline:
  - Stage 0 registers the partial-product rows.
  - Stages 1..LEVELS each register one tree level.
  - The last stage drives out_product and out_tag directly from registers.
- Each stage carries a valid bit, the tag and the data.
- Stall policy is a global stall: stall = out_valid && !out_ready.
  - When stalled, every stage holds its contents.
  - in_ready = !stall.
  - No bubble collapsing.
- Bubbles (no input transfer) propagate as invalid stages. Data in invalid stages is don't-care, but it must never produce out_valid.
- Results leave strictly in input order.

## Timing
- Latency: LAT = LEVELS + 1 cycles from input transfer to out_valid when unstalled. For WIDTH=8, LAT = 4.
- Throughput: one transfer per cycle with out_ready held high.
- in_ready is combinational from out_ready and out_valid only; there is no path from in_valid.
- out_valid, out_product and out_tag are registered and stable while stalled. Once asserted, out_valid holds until the output transfer.
- Reset values:
  - All stage valid bits = 0; out_valid = 0.
  - out_product = 0; out_tag = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Internal data registers need not be reset.
- Reset mid-operation: all in-flight operations are discarded with no output. Inputs presented while rst = 1 are ignored.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle both complete.
  - A stall in cycle n freezes the beat offered in cycle n: it is not accepted, because in_ready = 0.
- Edge operands:
  - Signed: −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2) must be correct (no overflow in 2·WIDTH bits).
  - Unsigned: the all-ones × all-ones result must be correct.

## Structure
- Shared package mult_pkg holds:
  - the function clog2;
  - the LEVELS/LAT derivation as constant functions of WIDTH;
  - the range check on WIDTH (elaboration error if WIDTH is not a power of two or is outside 4..32).
- Sub-module mult_pp_gen: combinational generator of the WIDTH extended, optionally negated rows. It is instantiated once, ahead of the stage-0 registers.
- The tree levels are generate loops in multiplier_pipe itself.

## Test plan
- WIDTH=8, unsigned 255 × 255, tag 0x3 → out_product 0xFE01, out_tag 0x3, exactly 4 cycles after the transfer.
- Signed corner cases, back-to-back with no gaps:
  - −128 × −128 → 0x4000.
  - −1 × 127 → 0xFF81.
  - −128 × 127 → 0xC080.
  - Results arrive on consecutive cycles, in order.
- Streaming: 1000 random beats with random in_signed, out_ready = 1 → all products match a reference model, one per cycle after 4 fill cycles.
- Backpressure:
  - Random out_ready (50 %) with continuous in_valid → no loss or duplication, order preserved.
  - in_ready = 0 exactly on stall cycles.
  - out_product stable while stalled.
- Reset mid-flight: rst pulsed with 3 beats in flight → no out_valid for those beats; the next beat after reset returns after 4 cycles with correct value.
- WIDTH=16, unsigned 0xFFFF × 0xFFFF → 0xFFFE0001 after LAT = 5.
- WIDTH=16, signed 0x8000 × 0x8000 → 0x40000000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined multiplier: log2, pipeline depth
// derivation and the legal-WIDTH predicate used at elaboration.
package mult_pkg;

   // Ceiling log2 of a positive value; constant-evaluable at elaboration
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(value)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Number of adder-tree levels needed to reduce WIDTH rows to one
   function automatic int unsigned mult_levels(input int unsigned width);
      return clog2(width);
   endfunction

   // Input-transfer to out_valid latency: one row stage plus one per tree level
   function automatic int unsigned mult_lat(input int unsigned width);
      return clog2(width) + 1;
   endfunction

   // WIDTH must be a power of two in 4..32
   function automatic bit mult_width_ok(input int unsigned width);
      return (width >= 4) && (width <= 32) && ((width & (width - 1)) == 0);
   endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational partial-product generator: one row per multiplier bit,
// extended to 2*WIDTH bits; in signed mode the top row is negated so the
// sign bit of the multiplier carries weight -2^(WIDTH-1).
module mult_pp_gen
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]                a,
   input  logic [WIDTH-1:0]                b,
   input  logic                            is_signed,
   output logic [WIDTH-1:0][2*WIDTH-1:0]   rows_c
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [PW-1:0] a_ext;

   // Extend the multiplicand once, then gate and shift it per multiplier bit
   always_comb begin
      a_ext  = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
      rows_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (b[i]) begin
            rows_c[i] = a_ext << i;
         end
      end
      if (is_signed) begin
         rows_c[WIDTH-1] = PW'(-rows_c[WIDTH-1]);
      end
   end

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with a balanced, fully registered
// partial-product adder tree and valid/ready handshakes on both sides.
// A single global stall freezes every stage while the output is blocked.
module multiplier_pipe
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned LEVELS = mult_levels(WIDTH);
   localparam int unsigned NODES  = 2 * WIDTH - 1;

   if (!mult_width_ok(WIDTH)) begin : g_bad_width
      $error("multiplier_pipe: WIDTH must be a power of two in 4..32");
   end

   if (TAG_W == 0) begin : g_bad_tag
      $error("multiplier_pipe: TAG_W must be at least 1");
   end

   // Tree nodes stored level by level: level k starts at 2*WIDTH - 2*(WIDTH>>k).
   // Level 0 holds the registered rows; the last entry is the root/product.
   logic [PW-1:0]              node [NODES];
   logic [WIDTH-1:0][PW-1:0]   rows_c;
   logic [LEVELS:0]            stage_valid;
   logic [TAG_W-1:0]           stage_tag [LEVELS+1];
   logic                       stall;

   assign stall    = stage_valid[LEVELS] & ~out_ready;
   assign in_ready = ~stall;

   assign out_valid   = stage_valid[LEVELS];
   assign out_product = node[NODES-1];
   assign out_tag     = stage_tag[LEVELS];

   mult_pp_gen #(
      .WIDTH (WIDTH)
   ) u_pp_gen (
      .a         (in_a),
      .b         (in_b),
      .is_signed (in_signed),
      .rows_c    (rows_c)
   );

   // Stage 0: capture the partial-product rows
   for (genvar j = 0; j < WIDTH; j++) begin : g_row
      // Row register, held while stalled
      always_ff @(posedge clk) begin
         if (!stall) begin
            node[j] <= rows_c[j];
         end
      end
   end

   // Stages 1..LEVELS: pairwise sums of the previous level
   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned SRC = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
      localparam int unsigned DST = 2 * WIDTH - 2 * (WIDTH >> k);

      for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_node
         if (k == LEVELS) begin : g_root
            // Root drives out_product, so it alone needs a defined reset value
            always_ff @(posedge clk) begin
               if (rst) begin
                  node[DST+j] <= '0;
               end else if (!stall) begin
                  node[DST+j] <= node[SRC+2*j] + node[SRC+2*j+1];
               end
            end
         end else begin : g_mid
            // Interior tree node, modulo-2^(2*WIDTH) add
            always_ff @(posedge clk) begin
               if (!stall) begin
                  node[DST+j] <= node[SRC+2*j] + node[SRC+2*j+1];
               end
            end
         end
      end
   end

   // Valid and tag shift alongside the data; bubbles travel as invalid stages
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid <= '0;
         for (int k = 0; k <= int'(LEVELS); k++) begin
            stage_tag[k] <= '0;
         end
      end else if (!stall) begin
         stage_valid  <= {stage_valid[LEVELS-1:0], in_valid};
         stage_tag[0] <= in_tag;
         for (int k = 1; k <= int'(LEVELS); k++) begin
            stage_tag[k] <= stage_tag[k-1];
         end
      end
   end

endmodule

// File: tb/tb_multiplier_pipe.sv
// Self-checking bench for multiplier_pipe: directed vector table, random
// streaming and backpressure against an arithmetic reference model,
// mid-flight reset, and a WIDTH=16 instance for the wide corner cases.
module tb_multiplier_pipe;

   localparam int unsigned W     = 8;
   localparam int unsigned TW    = 4;
   localparam int unsigned LAT   = 4;
   localparam int unsigned W16   = 16;
   localparam int unsigned LAT16 = 5;

   logic clk;
   logic rst;

   logic              in_valid, in_ready, in_signed;
   logic [W-1:0]      in_a, in_b;
   logic [TW-1:0]     in_tag, out_tag;
   logic              out_valid, out_ready;
   logic [2*W-1:0]    out_product;

   logic              d16_in_valid, d16_in_ready, d16_in_signed;
   logic [W16-1:0]    d16_in_a, d16_in_b;
   logic [TW-1:0]     d16_in_tag, d16_out_tag;
   logic              d16_out_valid, d16_out_ready;
   logic [2*W16-1:0]  d16_out_product;

   multiplier_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_signed   (in_signed),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_tag     (out_tag)
   );

   multiplier_pipe #(.WIDTH(W16), .TAG_W(TW)) u_dut16 (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (d16_in_valid),
      .in_ready    (d16_in_ready),
      .in_a        (d16_in_a),
      .in_b        (d16_in_b),
      .in_signed   (d16_in_signed),
      .in_tag      (d16_in_tag),
      .out_valid   (d16_out_valid),
      .out_ready   (d16_out_ready),
      .out_product (d16_out_product),
      .out_tag     (d16_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] prod;
      logic [TW-1:0]  tag;
      int             t;
   } exp_t;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           s;
      logic [TW-1:0]  tag;
      logic [2*W-1:0] prod;
   } vec_t;

   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   int             stall_cycles = 0;
   exp_t           sbq[$];
   bit             check_lat;
   bit             last_in_fire;
   bit             prev_stall;
   logic [2*W-1:0] prev_prod;
   logic [TW-1:0]  prev_tag;
   logic [2*W-1:0] next_exp;
   vec_t           tbl [12];

   // Plain integer product, operands interpreted per the signed flag
   function automatic longint ref_mul(input longint a, input longint b, input bit s, input int w);
      longint pa, pb;
      pa = a;
      pb = b;
      if (s && a[w-1]) pa = a - (longint'(1) << w);
      if (s && b[w-1]) pb = b - (longint'(1) << w);
      return pa * pb;
   endfunction

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock cycle of the 8-bit DUT: sample, score handshakes, advance
   task automatic cycle();
      exp_t e;
      #1;
      last_in_fire = 1'b0;
      if (rst) begin
         sbq.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
         if (prev_stall) begin
            check("hold_valid", longint'(out_valid), 1);
            check("hold_product", longint'(out_product), longint'(prev_prod));
            check("hold_tag", longint'(out_tag), longint'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("spurious_out_valid", longint'(out_valid), 0);
            end else begin
               e = sbq.pop_front();
               check("product", longint'(out_product), longint'(e.prod));
               check("tag", longint'(out_tag), longint'(e.tag));
               if (check_lat) check("latency", longint'(cyc - e.t), longint'(LAT));
            end
         end
         if (in_valid && in_ready) begin
            e.prod = next_exp;
            e.tag  = in_tag;
            e.t    = cyc;
            sbq.push_back(e);
            last_in_fire = 1'b1;
         end
         if (out_valid && !out_ready) stall_cycles++;
         prev_stall = out_valid && !out_ready;
         prev_prod  = out_product;
         prev_tag   = out_tag;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Wait (bounded) for all expected results, then confirm nothing extra appears
   task automatic drain();
      for (int n = 0; n < 64 && sbq.size() != 0; n++) cycle();
      check("drain_empty", longint'(sbq.size()), 0);
      repeat (LAT + 1) cycle();
   endtask

   task automatic rand_beat();
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      in_signed = 1'($urandom);
      in_tag    = TW'($urandom);
      next_exp  = (2*W)'(ref_mul(longint'(in_a), longint'(in_b), in_signed, W));
   endtask

   // Single beat through the 16-bit DUT with latency measurement
   task automatic run16(input logic [W16-1:0] a, input logic [W16-1:0] b, input logic s,
                        input logic [2*W16-1:0] exp_prod, input logic [TW-1:0] tag);
      int n;
      bit got;
      d16_in_valid  = 1'b1;
      d16_in_a      = a;
      d16_in_b      = b;
      d16_in_signed = s;
      d16_in_tag    = tag;
      #1;
      check("w16_in_ready", longint'(d16_in_ready), 1);
      @(posedge clk);
      @(negedge clk);
      d16_in_valid = 1'b0;
      n   = 1;
      got = 1'b0;
      while (!got && n < 20) begin
         #1;
         if (d16_out_valid) begin
            got = 1'b1;
         end else begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end
      end
      check("w16_latency", longint'(n), longint'(LAT16));
      check("w16_product", longint'(d16_out_product), longint'(exp_prod));
      check("w16_tag", longint'(d16_out_tag), longint'(tag));
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
      out_ready = 1'b1;
      d16_in_valid = 1'b0; d16_in_a = '0; d16_in_b = '0; d16_in_signed = 1'b0;
      d16_in_tag = '0; d16_out_ready = 1'b1;
      check_lat = 1'b0; prev_stall = 1'b0; next_exp = '0; last_in_fire = 1'b0;
      prev_prod = '0; prev_tag = '0;

      tbl[0]  = '{8'h80, 8'h80, 1'b1, 4'h1, 16'h4000};
      tbl[1]  = '{8'hFF, 8'h7F, 1'b1, 4'h2, 16'hFF81};
      tbl[2]  = '{8'h80, 8'h7F, 1'b1, 4'h3, 16'hC080};
      tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 4'h4, 16'h0001};
      tbl[4]  = '{8'h7F, 8'h7F, 1'b1, 4'h5, 16'h3F01};
      tbl[5]  = '{8'h80, 8'h80, 1'b0, 4'h6, 16'h4000};
      tbl[6]  = '{8'hFF, 8'h01, 1'b0, 4'h7, 16'h00FF};
      tbl[7]  = '{8'h01, 8'hFF, 1'b1, 4'h8, 16'hFFFF};
      tbl[8]  = '{8'h00, 8'h9C, 1'b1, 4'h9, 16'h0000};
      tbl[9]  = '{8'hFF, 8'h80, 1'b0, 4'hA, 16'h7F80};
      tbl[10] = '{8'h80, 8'h01, 1'b1, 4'hB, 16'hFF80};
      tbl[11] = '{8'h0F, 8'hF0, 1'b0, 4'hC, 16'h0E10};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_out_product", longint'(out_product), 0);
      check("reset_out_tag", longint'(out_tag), 0);
      check("reset_in_ready", longint'(in_ready), 1);
      @(negedge clk);

      // Unsigned all-ones, exact latency
      check_lat = 1'b1;
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_signed = 1'b0; in_tag = 4'h3;
      next_exp = 16'hFE01;
      cycle();
      in_valid = 1'b0;
      drain();

      // Directed table, back-to-back
      for (int i = 0; i < 12; i++) begin
         in_valid  = 1'b1;
         in_a      = tbl[i].a;
         in_b      = tbl[i].b;
         in_signed = tbl[i].s;
         in_tag    = tbl[i].tag;
         next_exp  = tbl[i].prod;
         cycle();
      end
      in_valid = 1'b0;
      drain();

      // Random streaming at full rate
      for (int i = 0; i < 1000; i++) begin
         in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      in_valid = 1'b0;
      drain();

      // Random backpressure with continuous offers
      check_lat = 1'b0;
      last_in_fire = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (last_in_fire) rand_beat();
         in_valid  = 1'b1;
         out_ready = 1'($urandom);
         cycle();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      checks++;
      if (stall_cycles == 0) begin
         errors++;
         $display("FAIL bp_stalls: got %0d stall cycles, expected at least 1", stall_cycles);
      end

      // Reset with three beats in flight
      check_lat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      rand_beat();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("flushed_out_valid", longint'(out_valid), 0);
         cycle();
      end
      in_valid = 1'b1;
      rand_beat();
      cycle();
      in_valid = 1'b0;
      drain();

      // Wide instance corner cases
      run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 4'h6);
      run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, 4'h9);
      run16(16'hFFFF, 16'h7FFF, 1'b1, 32'hFFFF8001, 4'hE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
